top_sdiv_12s_12s_12_seq: RTL and testbench

Sequential signed integer divider. It is the inverse-operation companion to the top-level signed 12×12→12 multiplier. It accepts a dividend/divisor pair over a valid/ready handshake and computes quotient and remainder with one restoring step per cycle. It returns the results over a second valid/ready handshake. It sits in the same top-level datapath as the multiplier and shares its two's-complement, truncate-to-WIDTH result convention.

---
 rtl/top_div_pkg.sv | 22 ++
 rtl/top_div_step.sv | 30 +++
 rtl/top_sdiv_12s_12s_12_seq.sv | 145 ++++++++++++++
 tb/tb_top_sdiv_12s_12s_12_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_div_pkg.sv
// Shared definitions for the sequential signed divider.
//   - div_state_e  : controller states
//   - DefaultWidth : default operand/result width
//   - DefaultCntW  : iteration counter width for DefaultWidth
//   - cnt_width()  : iteration counter width for an arbitrary WIDTH
package top_div_pkg;

    localparam int unsigned DefaultWidth = 12;
    localparam int unsigned DefaultCntW  = $clog2(DefaultWidth);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/top_div_step.sv
// One restoring-division step (purely combinational).
//   rem_i : low WIDTH-1 bits of the partial remainder (the top bit is always 0)
//   bit_i : next dividend bit shifted into the remainder
//   dvs_i : divisor magnitude
//   rem_o : next partial remainder
//   q_o   : quotient bit produced by this step
module top_div_step
    import top_div_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-2:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {rem_i, bit_i};
        // One extra bit so the sign of the difference is directly visible.
        trial   = {1'b0, shifted} - {1'b0, dvs_i};
        q_o     = ~trial[WIDTH];
        rem_o   = q_o ? trial[WIDTH-1:0] : shifted;
    end

endmodule

// File: rtl/top_sdiv_12s_12s_12_seq.sv
// Sequential signed divider, one restoring step per cycle.
//   ap_clk, ap_rst_n     : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (dividend, divisor)
//   out_valid / out_ready: result handshake (quotient, remainder, div_zero)
// Quotient truncates toward zero, remainder takes the dividend's sign, and
// results wrap to WIDTH bits (so -2^(WIDTH-1) / -1 yields -2^(WIDTH-1)).
// Divide by zero returns quotient -1, remainder = dividend, div_zero = 1.
module top_sdiv_12s_12s_12_seq
    import top_div_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    localparam int unsigned     CntW    = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    // dvd_q shifts dividend magnitude out at the top and quotient bits in at the bottom.
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // The partial remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
    // so its top bit is never set and is not passed to the step.
    top_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q[WIDTH-2:0]),
        .bit_i (dvd_q[WIDTH-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Two's-complement negation of -2^(WIDTH-1) gives the correct
                    // unsigned magnitude 2^(WIDTH-1).
                    dvd_d     = dividend[WIDTH-1] ? -dividend : dividend;
                    dvs_d     = divisor[WIDTH-1] ? -divisor : divisor;
                    neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    neg_rem_d = dividend[WIDTH-1];
                    rem_d     = '0;
                    count_d   = '0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d   = step_rem;
                dvd_d   = {dvd_q[WIDTH-2:0], step_q};
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = neg_quo_q ? -dvd_q : dvd_q;
                remainder_d = neg_rem_q ? -rem_q : rem_q;
                div_zero_d  = 1'b0;
                count_d     = '0;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_top_sdiv_12s_12s_12_seq.sv
// Self-checking bench for top_sdiv_12s_12s_12_seq (WIDTH = 12).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_top_sdiv_12s_12s_12_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [11:0] dividend = '0;
    logic [11:0] divisor = '0;
    logic        in_ready;
    logic        out_valid;
    logic [11:0] quotient;
    logic [11:0] remainder;
    logic        div_zero;

    int checks = 0;
    int errors = 0;

    top_sdiv_12s_12s_12_seq #(
        .WIDTH (12)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial forever #5 ap_clk = ~ap_clk;

    // Reference: plain signed integer division, truncated toward zero, wrapped to 12 bits.
    task automatic model(input logic [11:0] a, input logic [11:0] b,
                         output logic [11:0] q, output logic [11:0] r, output logic dz);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q  = 12'hFFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 12'(ai / bi);
            r  = 12'(ai % bi);
            dz = 1'b0;
        end
    endtask

    // Presents one pair (called on a falling edge). lat counts rising edges from the
    // accept edge (inclusive) to the edge on which out_valid rises.
    task automatic run_op(input logic [11:0] a, input logic [11:0] b,
                          output int lat, output bit timed_out);
        int w;
        timed_out = 1'b0;
        lat       = 0;
        w         = 0;
        while (!in_ready && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge ap_clk);
        lat = 1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 60) begin
            @(negedge ap_clk);
            lat++;
        end
        if (!out_valid) timed_out = 1'b1;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 12'h0, 12'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b q=%h r=%h dz=%b, want rdy=1 vld=0 q=000 r=000 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
    endtask

    task automatic test_directed();
        logic [11:0] ta [8] = '{12'h064, 12'hF9C, 12'h064, 12'hF9C, 12'h800, 12'h7FF, 12'h005, 12'h000};
        logic [11:0] tb [8] = '{12'h007, 12'h007, 12'hFF9, 12'hFF9, 12'hFFF, 12'h800, 12'h000, 12'hFFB};
        logic [11:0] tq [8] = '{12'h00E, 12'hFF2, 12'hFF2, 12'h00E, 12'h800, 12'h000, 12'hFFF, 12'h000};
        logic [11:0] tr [8] = '{12'h002, 12'hFFE, 12'h002, 12'hFFE, 12'h000, 12'h7FF, 12'h005, 12'h000};
        logic        tz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int lat;
        bit to;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL directed_timeout[%0d]: no result within bound", i);
                continue;
            end
            checks++;
            if ({quotient, remainder, div_zero} !== {tq[i], tr[i], tz[i]}) begin
                errors++;
                $display("FAIL directed[%0d] %h/%h: got q=%h r=%h dz=%b, want q=%h r=%h dz=%b",
                         i, ta[i], tb[i], quotient, remainder, div_zero, tq[i], tr[i], tz[i]);
            end
            checks++;
            if (lat !== (tz[i] ? 1 : 14)) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges, want %0d", i, lat, tz[i] ? 1 : 14);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        out_ready = 1'b0;
        run_op(12'd100, 12'd7, lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL backpressure_timeout: no result within bound");
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            checks++;
            if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, 12'h00E, 12'h002, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b q=%h r=%h dz=%b, want 1 0 00e 002 0",
                         i, out_valid, in_ready, quotient, remainder, div_zero);
            end
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        @(negedge ap_clk);
    endtask

    task automatic test_reset_mid_op();
        int lat;
        bit to;
        // Previous test left q=00e, r=002 in the result registers.
        out_ready = 1'b1;
        dividend  = 12'd77;
        divisor   = 12'd5;
        in_valid  = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, quotient, remainder, div_zero} !== {1'b1, 1'b0, 12'h0, 12'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_op: got rdy=%b vld=%b q=%h r=%h dz=%b, want rdy=1 vld=0 q=000 r=000 dz=0",
                     in_ready, out_valid, quotient, remainder, div_zero);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: got vld=%b, want 0", out_valid);
        end
        run_op(12'd9, 12'd3, lat, to);
        checks++;
        if (to || {quotient, remainder, div_zero} !== {12'h003, 12'h000, 1'b0} || lat != 14) begin
            errors++;
            $display("FAIL reset_recover 9/3: got q=%h r=%h dz=%b lat=%0d to=%b, want q=003 r=000 dz=0 lat=14",
                     quotient, remainder, div_zero, lat, to);
        end
        finish_op();
    endtask

    function automatic logic [11:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 12'h000;
            1:       return 12'h800;
            2:       return 12'hFFF;
            3:       return 12'(int'($urandom_range(0, 15)) - 8);
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic test_random(input int n);
        logic [11:0] a, b, eq, er;
        logic        ez;
        int          lat;
        int          w;
        bit          hs;
        for (int k = 0; k < n; k++) begin
            a = pick_operand();
            b = pick_operand();
            model(a, b, eq, er, ez);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge ap_clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_idle_ready[%0d]: got rdy=%b, want 1", k, in_ready);
            end
            dividend = a;
            divisor  = b;
            in_valid = 1'b1;
            @(posedge ap_clk);
            @(negedge ap_clk);
            lat = 1;
            // Junk operands while busy must be ignored.
            while (!out_valid && lat < 60) begin
                in_valid  = 1'($urandom);
                dividend  = 12'($urandom);
                divisor   = 12'($urandom);
                out_ready = 1'($urandom);
                @(negedge ap_clk);
                lat++;
            end
            checks++;
            if (!out_valid || {quotient, remainder, div_zero} !== {eq, er, ez} || lat != (ez ? 1 : 14)) begin
                errors++;
                $display("FAIL random[%0d] %h/%h: got vld=%b q=%h r=%h dz=%b lat=%0d, want q=%h r=%h dz=%b lat=%0d",
                         k, a, b, out_valid, quotient, remainder, div_zero, lat, eq, er, ez, ez ? 1 : 14);
            end
            w  = 0;
            hs = 1'b0;
            while (!hs && w < 50) begin
                in_valid  = 1'($urandom);
                out_ready = 1'($urandom);
                hs        = out_ready;
                @(posedge ap_clk);
                @(negedge ap_clk);
                if (!hs) begin
                    checks++;
                    if ({out_valid, in_ready, quotient, remainder, div_zero} !== {1'b1, 1'b0, eq, er, ez}) begin
                        errors++;
                        $display("FAIL random_hold[%0d]: got vld=%b rdy=%b q=%h r=%h dz=%b, want 1 0 %h %h %b",
                                 k, out_valid, in_ready, quotient, remainder, div_zero, eq, er, ez);
                    end
                end
                w++;
            end
            in_valid = 1'b0;
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL random_handshake[%0d]: got vld=%b rdy=%b, want vld=0 rdy=1", k, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        @(negedge ap_clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
